// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt round-robin arbiter.
//   N_SRC   : number of interrupt sources (matches the 32-to-5 grant encoder)
//   PTR_W   : width of the round-robin pointer, log2(N_SRC)
//   state_t : arbiter FSM state, IDLE (no grant held) / GRANT (grant held)
package irq_pkg;

    localparam int N_SRC = 32;
    localparam int PTR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of 'eligible' at or above position 'ptr',
// wrapping past the top bit back to 0.
//   eligible : request vector (pending & mask)
//   ptr      : search start position
//   sel      : one-hot selection (zero when eligible is zero)
//   idx      : binary index of the selection, only meaningful when sel != 0
module rr_pick #(
    parameter int N_SRC = irq_pkg::N_SRC,
    parameter int PTR_W = irq_pkg::PTR_W
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_SRC-1:0] sel,
    output logic [PTR_W-1:0] idx
);

    logic [N_SRC-1:0] rot;
    logic [N_SRC-1:0] first;
    logic [PTR_W-1:0] first_idx;

    // Rotate right by ptr so the search start lands on bit 0. The index sum
    // relies on PTR_W-bit wrap-around, which is exact because N_SRC == 2**PTR_W.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot_right
        assign rot[gi] = eligible[PTR_W'(gi) + ptr];
    end

    // Isolate the lowest set bit of the rotated vector.
    assign first = rot & (~rot + 1'b1);

    always_comb begin
        first_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first_idx = PTR_W'(i);
            end
        end
    end

    // Rotate the isolated bit back left by ptr into its original position.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot_left
        assign sel[gi] = first[PTR_W'(gi) - ptr];
    end

    assign idx = first_idx + ptr;

endmodule

// File: rtl/irq_rr_arbiter.sv
// Edge-triggered interrupt arbiter with round-robin selection.
// Rising edges on irq_in latch into a pending register; pending & mask is
// arbitrated round-robin and the winner is held as a registered one-hot
// grant until ack.
//   clk, rst   : clock, synchronous active-high reset
//   irq_in     : raw interrupt lines, rising edge = request
//   mask_we    : load mask_wdata into the mask register
//   mask_wdata : new mask, 1 = source enabled
//   ack        : CPU has taken the current grant
//   gnt        : registered grant, one-hot or zero
//   gnt_valid  : gnt holds a valid grant
//   pending    : raw pending register (unmasked) for status reads
module irq_rr_arbiter #(
    parameter int N_SRC = irq_pkg::N_SRC,
    parameter int PTR_W = irq_pkg::PTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             ack,
    output logic [N_SRC-1:0] gnt,
    output logic             gnt_valid,
    output logic [N_SRC-1:0] pending
);

    irq_pkg::state_t state_reg, state_next;

    logic [N_SRC-1:0] irq_q_reg;
    logic [N_SRC-1:0] pending_reg, pending_next;
    logic [N_SRC-1:0] mask_reg;
    logic [N_SRC-1:0] gnt_reg, gnt_next;
    logic             gnt_valid_reg, gnt_valid_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] gnt_idx_reg, gnt_idx_next;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] pick_sel;
    logic [PTR_W-1:0] pick_idx;

    assign rise     = irq_in & ~irq_q_reg;
    assign clr      = (ack && gnt_valid_reg) ? gnt_reg : '0;
    // Set is OR-ed in after the clear, so an edge arriving with its own ack
    // re-arms the source instead of being lost.
    assign pending_next = (pending_reg & ~clr) | rise;
    assign eligible = pending_reg & mask_reg;

    rr_pick #(
        .N_SRC (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .sel      (pick_sel),
        .idx      (pick_idx)
    );

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_valid_next = gnt_valid_reg;
        gnt_idx_next   = gnt_idx_reg;
        ptr_next       = ptr_reg;
        unique case (state_reg)
            irq_pkg::IDLE: begin
                if (eligible != '0) begin
                    gnt_next       = pick_sel;
                    gnt_idx_next   = pick_idx;
                    gnt_valid_next = 1'b1;
                    state_next     = irq_pkg::GRANT;
                end
            end
            irq_pkg::GRANT: begin
                // Mask changes are ignored here; only ack releases the grant.
                if (ack) begin
                    gnt_next       = '0;
                    gnt_valid_next = 1'b0;
                    ptr_next       = gnt_idx_reg + 1'b1;
                    state_next     = irq_pkg::IDLE;
                end
            end
            default: begin
                state_next = irq_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= irq_pkg::IDLE;
            irq_q_reg     <= '0;
            pending_reg   <= '0;
            mask_reg      <= '0;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_idx_reg   <= '0;
            ptr_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            irq_q_reg     <= irq_in;
            pending_reg   <= pending_next;
            if (mask_we) begin
                mask_reg <= mask_wdata;
            end
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
            gnt_idx_reg   <= gnt_idx_next;
            ptr_reg       <= ptr_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign pending   = pending_reg;

endmodule

// File: tb/tb_irq_rr_arbiter.sv
// Self-checking bench for irq_rr_arbiter: directed scenarios followed by
// randomized traffic, checked against a cycle-level reference model and a
// grant scoreboard.
module tb_irq_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] irq_in = '0;
    logic        mask_we = 1'b0;
    logic [31:0] mask_wdata = '0;
    logic        ack = 1'b0;
    logic [31:0] gnt;
    logic        gnt_valid;
    logic [31:0] pending;

    always #5 clk = ~clk;

    irq_rr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .pending    (pending)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending/mask as bit vectors, pointer and held grant
    // as plain integers (-1 = no grant held).
    logic [31:0] m_pending = '0;
    logic [31:0] m_mask    = '0;
    logic [31:0] m_irq_q   = '0;
    int          m_ptr     = 0;
    int          m_gidx    = -1;
    bit          started   = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Walk positions ptr, ptr+1, ... modulo 32 and return the first requester.
    function automatic int rr_search(input logic [31:0] elig, input int p);
        for (int k = 0; k < 32; k++) begin
            if (elig[(p + k) % 32]) return (p + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [31:0] clr;
        logic [31:0] rise;
        int          nidx;
        if (rst) begin
            m_pending = '0; m_mask = '0; m_irq_q = '0;
            m_ptr = 0; m_gidx = -1; started = 1'b1;
        end else begin
            clr  = '0;
            rise = irq_in & ~m_irq_q;
            if (m_gidx >= 0) begin
                if (ack) begin
                    clr[m_gidx] = 1'b1;
                    m_ptr  = (m_gidx + 1) % 32;
                    m_gidx = -1;
                end
            end else begin
                nidx = rr_search(m_pending & m_mask, m_ptr);
                if (nidx >= 0) begin
                    m_gidx = nidx;
                    exp_q.push_back(32'h1 << nidx);
                end
            end
            m_pending = (m_pending & ~clr) | rise;
            if (mask_we) m_mask = mask_wdata;
            m_irq_q = irq_in;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: per-cycle status against the model, plus the scoreboard pop
    // whenever the DUT presents a new grant.
    initial begin
        bit          prev_valid;
        logic [31:0] held;
        prev_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (started) begin
                chk("gnt_valid", 32'(gnt_valid), 32'(m_gidx >= 0));
                chk("pending", pending, m_pending);
                chk("gnt_onehot", gnt & (gnt - 32'h1), 32'h0);
                if (gnt_valid && !prev_valid) begin
                    if (exp_q.size() == 0) chk("sb_unexpected_grant", gnt, 32'h0);
                    else begin
                        held = exp_q.pop_front();
                        chk("sb_grant", gnt, held);
                    end
                end else if (gnt_valid) begin
                    chk("gnt_hold", gnt, held);
                end else begin
                    chk("gnt_zero", gnt, 32'h0);
                end
                prev_valid = gnt_valid;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input string name, input int bound);
        int c = 0;
        while (!gnt_valid && c < bound) begin
            tick();
            c++;
        end
        chk({name, "_timeout"}, 32'(gnt_valid), 32'h1);
    endtask

    logic [31:0] rr_exp [3] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0020};

    initial begin
        // Reset with all lines high: edges appear right after release.
        rst = 1'b1; irq_in = 32'hFFFF_FFFF;
        tick(2);
        rst = 1'b0;
        tick();
        chk("rst_gnt", gnt, 32'h0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_pending_all", pending, 32'hFFFF_FFFF);
        irq_in = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Single request on source 5.
        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF;
        tick();
        mask_we = 1'b0; irq_in = 32'h20;
        tick();
        irq_in = '0;
        chk("single_pending", pending, 32'h20);
        chk("single_not_yet", 32'(gnt_valid), 32'h0);
        tick();
        chk("single_gnt", gnt, 32'h20);
        tick(10);
        chk("single_hold", gnt, 32'h20);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("single_cleared", pending, 32'h0);

        // Round robin from ptr 6 over sources 0, 5, 31.
        irq_in = 32'h8000_0021;
        tick();
        irq_in = '0;
        for (int i = 0; i < 3; i++) begin
            wait_grant("rr", 8);
            chk("rr_order", gnt, rr_exp[i]);
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end

        // Set/clear collision on source 3.
        irq_in = 32'h8;
        tick();
        irq_in = '0;
        wait_grant("coll", 8);
        chk("coll_gnt", gnt, 32'h8);
        ack = 1'b1; irq_in = 32'h8;
        tick();
        ack = 1'b0; irq_in = '0;
        chk("coll_pending_kept", pending & 32'h8, 32'h8);
        tick();
        chk("coll_regrant", gnt, 32'h8);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Mask behaviour on source 4.
        mask_we = 1'b1; mask_wdata = '0;
        tick();
        mask_we = 1'b0; irq_in = 32'h10;
        tick();
        irq_in = '0;
        tick(3);
        chk("mask_blocked", 32'(gnt_valid), 32'h0);
        chk("mask_pending", pending, 32'h10);
        mask_we = 1'b1; mask_wdata = 32'h10;
        tick();
        mask_we = 1'b0;
        chk("mask_not_yet", 32'(gnt_valid), 32'h0);
        tick();
        chk("mask_gnt", gnt, 32'h10);
        mask_we = 1'b1; mask_wdata = '0;
        tick();
        mask_we = 1'b0;
        tick(3);
        chk("mask_clear_keeps_gnt", gnt, 32'h10);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Reset while a grant is held and more requests are pending.
        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF;
        tick();
        mask_we = 1'b0; irq_in = 32'h300;
        tick();
        irq_in = '0;
        wait_grant("midrst", 8);
        chk("midrst_gnt", gnt, 32'h100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_gnt_zero", gnt, 32'h0);
        chk("midrst_valid", 32'(gnt_valid), 32'h0);
        chk("midrst_pending", pending, 32'h0);

        // Randomized traffic: toggling lines, mask writes, acks in both
        // states, occasional resets.
        mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF;
        tick();
        for (int c = 0; c < 3000; c++) begin
            irq_in     = irq_in ^ ($urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = $urandom | $urandom;
            ack        = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0; mask_we = 1'b0; irq_in = '0;
        tick(2);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_rr_arbiter.md
# irq_rr_arbiter

Latches 32 edge-triggered interrupt lines into a pending register, masks them, and selects one with a round-robin pointer. The selected request is presented as a registered one-hot 32-bit grant, held until the CPU acknowledges it. The grant feeds the design's 32-to-5 one-hot index encoder directly. `gnt` is therefore guaranteed to be either all-zero or exactly one-hot.

## Interface
Parameters:
- `N_SRC`, default 32: number of interrupt sources. Fixed at 32 to match the encoder width.
- `PTR_W`, default 5: round-robin pointer width, log2(`N_SRC`).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `irq_in` input 32: raw interrupt lines; a rising edge is a request.
- `mask_we` input 1: write enable for the mask register.
- `mask_wdata` input 32: new mask value; a 1 enables the corresponding source.
- `ack` input 1: CPU has taken the current grant.
- `gnt` output 32: registered grant; one-hot or zero.
- `gnt_valid` output 1: `gnt` holds a valid grant.
- `pending` output 32: raw pending register, before masking, for status reads.

## Operation
- **Edge detect:** `irq_q <= irq_in` every cycle. `rise = irq_in & ~irq_q`.
- **Pending update:** `pending <= (pending & ~clr) | rise`. `clr` is the one-hot `gnt` when `ack && gnt_valid`, else 0.
  - If a source rises in the same cycle its grant is acknowledged, the set wins and the bit stays 1. The new edge is not lost.
- **Mask:** `mask <= mask_wdata` when `mask_we`. `eligible = pending & mask`.
- **FSM:** two states, IDLE and GRANT.
  - **IDLE:** if `eligible != 0`, pick the lowest-index set bit at index >= `ptr`, wrapping past 31 to 0. Register its one-hot value into `gnt`, set `gnt_valid`, go to GRANT. If `eligible == 0`, stay in IDLE with `gnt = 0`.
  - **GRANT:** hold `gnt` and `gnt_valid` stable until `ack`. On `ack`:
    - clear the granted pending bit;
    - `ptr <= granted_index + 1`, mod 32 (31 wraps to 0);
    - `gnt <= 0`, `gnt_valid <= 0`;
    - go to IDLE.
- **Mask writes during GRANT** never retract or change the current grant. The mask applies from the next IDLE selection.
- **`ack` in IDLE** is ignored and has no effect on pending or `ptr`.
- **Pointer arithmetic:** `PTR_W` bits, natural wrap. The search covers all 32 positions exactly once per selection.

## Timing
- **Reset values:** `gnt = 0`, `gnt_valid = 0`, `pending = 0`, `mask = 0` (all sources disabled), `irq_q = 0`, `ptr = 0`, state = IDLE.
- **Line high at reset release:** because `irq_q` resets to 0, such a line registers as an edge in the first cycle after reset.
- **Request latency:**
  - Rising edge of `irq_in` visible at clock edge k: pending set at edge k.
  - `gnt`/`gnt_valid` asserted after edge k+1, provided the source is enabled and the FSM is in IDLE.
- **Ack to next grant:** `ack` sampled at edge m drops `gnt_valid` after edge m. The earliest next grant is after edge m+1, so grants are back-to-back at most every 2 cycles.
- **Reset mid-grant:** returns to IDLE with all state cleared. Pending requests are discarded.
- **Reset priority:** `rst` overrides `mask_we`, `ack` and edge capture in the same cycle.

## Structure
- **Shared package `irq_pkg`:**
  - `N_SRC = 32`, `PTR_W = 5`;
  - FSM state typedef {IDLE, GRANT}, 1-bit encoding.
- **Sub-module `rr_pick`:** combinational. Inputs are the 32-bit `eligible` vector and the 5-bit `ptr`. Outputs are the one-hot select and the 5-bit index.
  - Implement as a rotate-right by `ptr`, then find-first-set, then rotate-left.
  - The index output is used only for the pointer update. Downstream index generation remains the encoder's job.
- **Top level:** holds the edge detector, pending, mask, `ptr`, FSM and output registers.

## Test plan
- **Reset defaults:** hold `rst` 2 cycles with `irq_in = 0xFFFFFFFF`, then release.
  - After release: `gnt = 0` and `gnt_valid = 0` while `mask = 0`.
  - `pending = 0xFFFFFFFF` one cycle after release.
- **Single request:** `mask = 0xFFFFFFFF`, pulse `irq_in[5]`.
  - `gnt = 0x00000020` with `gnt_valid = 1` exactly 2 edges after the pulse.
  - `gnt` stays stable for 10 cycles without `ack`.
  - `ack` clears `pending[5]`; `ptr` becomes 6.
- **Round robin and wrap:** pending bits 0, 5 and 31 set, `ptr = 6`, acking each grant immediately.
  - Grant order is `0x80000000`, `0x00000001`, `0x00000020`.
  - `ptr` wraps from 31 to 0.
- **Set/clear collision:** re-pulse `irq_in[3]` in the same cycle as `ack` of grant `0x00000008`.
  - `pending[3]` remains 1.
  - Bit 3 is re-granted 2 cycles later.
- **Mask behaviour:**
  - Pending `0x00000010` with `mask = 0`: no grant.
  - Write `mask = 0x00000010`: grant appears 1 cycle later.
  - Clearing the mask during GRANT leaves `gnt` unchanged until `ack`.
- **Reset mid-grant:** assert `rst` while `gnt = 0x00000100`. On the next edge, `gnt = 0`, `gnt_valid = 0`, `pending = 0`.
